// File: rtl/freq_meter_pkg.sv
// Shared definitions for the frequency-meter input path: the level-filter
// state encoding, the default build constants, and a level-decode helper.
package freq_meter_pkg;

    localparam int SYNC_STAGES_DEF = 2;
    localparam int FILT_CYCLES_DEF = 3;
    localparam int TIMEOUT_CYC_DEF = 50_000_000;

    // Filter states: two settled levels plus a qualifying state for each
    // direction of change.
    typedef enum logic [1:0] {
        LOW      = 2'd0,
        CHK_HIGH = 2'd1,
        HIGH     = 2'd2,
        CHK_LOW  = 2'd3
    } filt_state_t;

    // The accepted level is high while settled high or while qualifying a fall.
    function automatic logic state_is_high(input filt_state_t st);
        return (st == HIGH) || (st == CHK_LOW);
    endfunction

endpackage

// File: rtl/sync_chain.sv
// Multi-flop synchronizer for a single asynchronous bit. Only the last stage
// is meant to be used by downstream logic.
module sync_chain #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] r_sync;
    logic [STAGES-1:0] w_stage_in;

    // Build the shift input for every stage: stage 0 takes the raw input,
    // every later stage takes its predecessor.
    genvar gi;
    generate
        for (gi = 0; gi < STAGES; gi++) begin : g_stage
            if (gi == 0) begin : g_first
                assign w_stage_in[gi] = d;
            end else begin : g_rest
                assign w_stage_in[gi] = r_sync[gi-1];
            end
        end
    endgenerate

    // Shift the chain every clock; reset clears all stages.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sync <= '0;
        end else begin
            r_sync <= w_stage_in;
        end
    end

    assign q = r_sync[STAGES-1];

endmodule

// File: rtl/clk_in_cond.sv
// Input conditioner for an external clock/signal being measured:
// synchronize, debounce with a level-qualifying FSM, emit one strobe per
// accepted rising edge, and flag loss of signal after a period with no edges.
// Optional build macro: CLK_IN_COND_GLITCH_CNT_EN adds a saturating 16-bit
// count of rejected level changes on output glitch_cnt.
module clk_in_cond
    import freq_meter_pkg::*;
#(
    parameter int SYNC_STAGES = SYNC_STAGES_DEF,
    parameter int FILT_CYCLES = FILT_CYCLES_DEF,
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clk_in,
    output logic        edge_pulse,
    output logic        sig_level,
    output logic        no_signal
`ifdef CLK_IN_COND_GLITCH_CNT_EN
    ,
    output logic [15:0] glitch_cnt
`endif
);

    localparam int TO_W = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC + 1);
    localparam logic [TO_W-1:0] TO_MAX = TO_W'(TIMEOUT_CYC);
    localparam logic [8:0] FILT_N = 9'(FILT_CYCLES);
    // A one-sample filter needs no qualifying state at all.
    localparam bit FILT_BYPASS = (FILT_CYCLES == 1);

    logic        w_s;
    filt_state_t r_state;
    filt_state_t w_state_next;
    logic [7:0]  r_cnt;
    logic [7:0]  w_cnt_next;
    logic [8:0]  w_cnt_inc;
    logic        w_rise_entry;
    logic        w_glitch;
    logic        r_rise_seen;
    logic        r_edge_pulse;
    logic        r_sig_level;
    logic [TO_W-1:0] r_to_cnt;

    sync_chain #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (clk_in),
        .q     (w_s)
    );

    assign w_cnt_inc = {1'b0, r_cnt} + 9'd1;

    // Filter state and qualification count register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= LOW;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end
    end

    // Next-state logic: a level change is accepted only after FILT_CYCLES
    // consecutive equal synchronized samples; any contrary sample aborts.
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_glitch     = 1'b0;
        case (r_state)
            LOW: begin
                if (w_s) begin
                    if (FILT_BYPASS) begin
                        w_state_next = HIGH;
                        w_cnt_next   = '0;
                    end else begin
                        w_state_next = CHK_HIGH;
                        w_cnt_next   = 8'd1;
                    end
                end
            end
            CHK_HIGH: begin
                if (!w_s) begin
                    w_state_next = LOW;
                    w_cnt_next   = '0;
                    w_glitch     = 1'b1;
                end else if (w_cnt_inc >= FILT_N) begin
                    w_state_next = HIGH;
                    w_cnt_next   = '0;
                end else begin
                    w_cnt_next   = w_cnt_inc[7:0];
                end
            end
            HIGH: begin
                if (!w_s) begin
                    if (FILT_BYPASS) begin
                        w_state_next = LOW;
                        w_cnt_next   = '0;
                    end else begin
                        w_state_next = CHK_LOW;
                        w_cnt_next   = 8'd1;
                    end
                end
            end
            CHK_LOW: begin
                if (w_s) begin
                    w_state_next = HIGH;
                    w_cnt_next   = '0;
                    w_glitch     = 1'b1;
                end else if (w_cnt_inc >= FILT_N) begin
                    w_state_next = LOW;
                    w_cnt_next   = '0;
                end else begin
                    w_cnt_next   = w_cnt_inc[7:0];
                end
            end
            default: begin
                w_state_next = LOW;
                w_cnt_next   = '0;
            end
        endcase
    end

    // Only a genuine low-to-high acceptance counts as an edge; returning to
    // HIGH after an aborted fall is not a new edge.
    assign w_rise_entry = (w_state_next == HIGH) &&
                          ((r_state == LOW) || (r_state == CHK_HIGH));

    // Edge strobe and level outputs, registered one cycle behind the state
    // change so both land in the same cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_rise_seen  <= 1'b0;
            r_edge_pulse <= 1'b0;
            r_sig_level  <= 1'b0;
        end else begin
            r_rise_seen  <= w_rise_entry;
            r_edge_pulse <= r_rise_seen;
            r_sig_level  <= state_is_high(r_state);
        end
    end

    // Loss-of-signal counter: restarts after each edge strobe, otherwise
    // counts up and sticks at the timeout value.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_to_cnt <= '0;
        end else if (r_edge_pulse) begin
            r_to_cnt <= '0;
        end else if (r_to_cnt != TO_MAX) begin
            r_to_cnt <= r_to_cnt + TO_W'(1);
        end
    end

    assign edge_pulse = r_edge_pulse;
    assign sig_level  = r_sig_level;
    assign no_signal  = (r_to_cnt == TO_MAX);

`ifdef CLK_IN_COND_GLITCH_CNT_EN
    logic [15:0] r_glitch_cnt;

    // Saturating count of aborted level changes.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_glitch_cnt <= '0;
        end else if (w_glitch && (r_glitch_cnt != 16'hFFFF)) begin
            r_glitch_cnt <= r_glitch_cnt + 16'd1;
        end
    end

    assign glitch_cnt = r_glitch_cnt;
`else
    // Abort detection is only consumed by the optional glitch counter.
    logic w_unused;
    assign w_unused = w_glitch;
`endif

endmodule

// File: doc/clk_in_cond.md
CLK_IN_COND -- requirements
Module: clk_in_cond

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, which sets the synchronizer flop count (legal range 2..4).
REQ-002 SHALL have parameter FILT_CYCLES, default 3, which sets the consecutive equal synchronized samples needed to accept a level change (legal range 1..255).
REQ-003 SHALL have parameter TIMEOUT_CYC, default 50_000_000, which sets the clk cycles without an accepted rising edge before no_signal asserts.
REQ-004 SHALL have port clk, input, 1 bit: system clock; every flop is on its rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-006 SHALL have port clk_in, input, 1 bit: raw, asynchronous external signal under measurement.
REQ-007 SHALL have port edge_pulse, output, 1 bit: single-cycle strobe for each accepted rising edge; this feeds the frequency counter.
REQ-008 SHALL have port sig_level, output, 1 bit: filtered, debounced level of clk_in.
REQ-009 SHALL have port no_signal, output, 1 bit: high while no accepted rising edge has occurred for TIMEOUT_CYC cycles.

Function
REQ-010 SHALL pass clk_in through a SYNC_STAGES-deep flop chain; the last stage is the signal s, and only s is used downstream.
REQ-011 SHALL implement the filter FSM with states LOW, CHK_HIGH, HIGH, CHK_LOW and an 8-bit count cnt.
REQ-012 In LOW with s=1, the FSM SHALL go to CHK_HIGH with cnt=1; in LOW with s=0 it SHALL stay in LOW.
REQ-013 In CHK_HIGH:
- s=0 SHALL return the FSM to LOW (glitch rejected);
- s=1 with cnt+1 >= FILT_CYCLES SHALL go to HIGH;
- otherwise cnt SHALL increment.
REQ-014 CHK_LOW SHALL mirror CHK_HIGH with polarity inverted: s=1 returns to HIGH, and completion goes to LOW.
REQ-015 With FILT_CYCLES=1, CHK states SHALL be bypassed: LOW goes directly to HIGH on the first s=1 sample, and HIGH goes to LOW likewise.
REQ-016 sig_level SHALL be a registered output: 1 in HIGH and CHK_LOW, 0 in LOW and CHK_HIGH.
REQ-017 edge_pulse SHALL be registered and high for exactly the one cycle after the FSM enters HIGH from LOW or CHK_HIGH; re-entry to HIGH from CHK_LOW SHALL NOT pulse.
REQ-018 Latency from a clean clk_in rise to edge_pulse SHALL be SYNC_STAGES+FILT_CYCLES+1 clk cycles (6 at defaults).
REQ-019 A clk_in pulse shorter than FILT_CYCLES synchronized samples SHALL produce no edge_pulse and no sig_level change.
REQ-020 The timeout counter SHALL clear to 0 on every edge_pulse cycle and otherwise increment, saturating at TIMEOUT_CYC.
REQ-021 no_signal SHALL be 1 exactly while the timeout counter equals TIMEOUT_CYC, and SHALL deassert the cycle after an edge_pulse.
REQ-022 The maximum accepted input rate SHALL be clk/(2*FILT_CYCLES+2); faster inputs may be filtered away, with no other failure mode.

Reset
REQ-023 With rst_n=0 at a clk edge:
- synchronizer flops SHALL go to 0;
- FSM SHALL go to LOW with cnt=0;
- edge_pulse and sig_level SHALL go to 0;
- timeout counter SHALL go to 0 and no_signal to 0.
REQ-024 Reset asserted mid-CHK_HIGH SHALL abort the pending edge, so no edge_pulse follows the release.
REQ-025 After release, a clk_in already high SHALL produce one edge_pulse after the REQ-018 latency.

Configuration
REQ-026 With CLK_IN_COND_GLITCH_CNT_EN defined, SHALL add output glitch_cnt, 16 bits:
- increments on each CHK_HIGH->LOW or CHK_LOW->HIGH abort;
- saturates at 0xFFFF;
- resets to 0.
REQ-027 Without CLK_IN_COND_GLITCH_CNT_EN, SHALL omit the glitch_cnt port and its logic; all other behaviour SHALL be identical.

Structure
REQ-028 A shared package freq_meter_pkg SHALL hold:
- the FSM state enum (LOW, CHK_HIGH, HIGH, CHK_LOW);
- the default constants SYNC_STAGES_DEF, FILT_CYCLES_DEF, TIMEOUT_CYC_DEF.
REQ-029 The synchronizer SHALL be one sub-module, sync_chain (parameter STAGES); the filter, edge and timeout logic SHALL stay in clk_in_cond.

Verification
REQ-030 Defaults; rst_n low 5 cycles, then clk_in rises and stays high -> single edge_pulse 6 cycles after the rise; sig_level=1 from that cycle on.
REQ-031 Defaults; 2-cycle clk_in high glitch, then 100 cycles low -> no edge_pulse, sig_level stays 0, glitch_cnt=1 (macro on).
REQ-032 Defaults; 1 MHz square wave for 1000 cycles at a 50 MHz clk -> exactly 20 edge_pulses, each 1 cycle wide and 50 cycles apart.
REQ-033 TIMEOUT_CYC=100; clk_in held low after one edge -> no_signal rises 100 cycles after edge_pulse, then falls 1 cycle after the next edge_pulse.
REQ-034 Defaults; rst_n pulsed low while in CHK_HIGH -> no edge_pulse from the aborted rise, and one edge_pulse 6 cycles after release if clk_in stays high.
REQ-035 FILT_CYCLES=1, SYNC_STAGES=2; clk_in toggles every 2 cycles -> edge_pulse every 4 cycles, latency 4.
